// File: rtl/pipe_pkg.sv
// Shared types and helpers for the PIPE transmit gearbox.
// Holds gearbox state enum, generation codes and beat slicing.
package pipe_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } gb_state_e;

    localparam logic [2:0] GEN1 = 3'd1;
    localparam logic [2:0] GEN2 = 3'd2;
    localparam logic [2:0] GEN3 = 3'd3;
    localparam logic [2:0] GEN4 = 3'd4;
    localparam logic [2:0] GEN5 = 3'd5;

    // Number of PIPE beats needed to carry one 32-bit word.
    function automatic logic [2:0] beats_f(input logic [5:0] width);
        logic [2:0] n;
        case (width)
            6'd8:    n = 3'd4;
            6'd16:   n = 3'd2;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Data lanes of beat idx, zero above the active width.
    function automatic logic [31:0] data_slice(input logic [31:0] w,
                                               input logic [5:0]  width,
                                               input logic [1:0]  idx);
        logic [7:0]  amt;
        logic [31:0] mask;
        amt  = {2'b00, width} * {6'd0, idx};
        mask = (width >= 6'd32) ? 32'hFFFF_FFFF
                                : ((32'd1 << width) - 32'd1);
        return (w >> amt) & mask;
    endfunction

    // K flags of beat idx, zero above the active byte count.
    function automatic logic [3:0] k_slice(input logic [3:0] k,
                                           input logic [5:0] width,
                                           input logic [1:0] idx);
        logic [2:0] nb;
        logic [4:0] amt;
        logic [3:0] mask;
        nb   = width[5:3];
        amt  = {2'b00, nb} * {3'b000, idx};
        mask = (nb >= 3'd4) ? 4'hF : 4'((5'd1 << nb) - 5'd1);
        return (k >> amt) & mask;
    endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Small synchronous show-ahead FIFO feeding the TX gearbox.
// Push while full is legal only together with a pop.
module pipe_sync_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    assign dout  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
        if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/pipe_tx_gearbox.sv
// 32-bit word to PIPE TxData gearbox, width chosen per generation.
// Define PIPE_TX_FIFO_EN to place an input FIFO ahead of it.
module pipe_tx_gearbox
    import pipe_pkg::*;
#(
    parameter int PIPE_WIDTH_GEN1 = 8,
    parameter int PIPE_WIDTH_GEN2 = 8,
    parameter int PIPE_WIDTH_GEN3 = 16,
    parameter int PIPE_WIDTH_GEN4 = 32,
    parameter int PIPE_WIDTH_GEN5 = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [2:0]  generation,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_k,
    input  logic        in_start_block,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] TxData,
    output logic [3:0]  TxDataK,
    output logic        TxDataValid,
    output logic        TxStartBlock,
    output logic        gen_error
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    function automatic logic [5:0] width_of(input logic [2:0] g);
        logic [5:0] w;
        case (g)
            GEN1:    w = 6'(PIPE_WIDTH_GEN1);
            GEN2:    w = 6'(PIPE_WIDTH_GEN2);
            GEN3:    w = 6'(PIPE_WIDTH_GEN3);
            GEN4:    w = 6'(PIPE_WIDTH_GEN4);
            default: w = 6'(PIPE_WIDTH_GEN5);
        endcase
        return w;
    endfunction

    gb_state_e   state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  k_q, k_d;
    logic [5:0]  wid_q, wid_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [3:0]  tx_k_q, tx_k_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_sb_q, tx_sb_d;
    logic        gen_err_q, gen_err_d;

    logic        gen_ok;
    logic [5:0]  cur_w;
    logic        last;
    logic        take;
    logic        load;
    logic        src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_k;
    logic        src_sb;
    logic        pending;

    assign gen_ok = (generation >= GEN1) && (generation <= GEN5);
    assign cur_w  = width_of(generation);
    assign last   = (state_q == ST_SHIFT) &&
                    ({1'b0, beat_q} == beats_f(wid_q) - 3'd1);
    assign take   = gen_ok && ((state_q == ST_IDLE) || last);
    assign load   = take && src_valid;

`ifdef PIPE_TX_FIFO_EN
    logic [36:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_push;
    logic        fifo_pop;

    assign fifo_pop  = take && !fifo_empty;
    assign in_ready  = reset_n && gen_ok && (!fifo_full || fifo_pop);
    assign fifo_push = in_valid && in_ready;
    assign src_valid = !fifo_empty;
    assign src_data  = fifo_dout[31:0];
    assign src_k     = fifo_dout[35:32];
    assign src_sb    = fifo_dout[36];
    assign pending   = !fifo_empty;

    pipe_sync_fifo #(
        .WIDTH (37),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     ({in_start_block, in_k, in_data}),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );
`else
    assign in_ready  = reset_n && take;
    assign src_valid = in_valid;
    assign src_data  = in_data;
    assign src_k     = in_k;
    assign src_sb    = in_start_block;
    assign pending   = 1'b0;
`endif

    // Next word/beat selection and registered PIPE output values.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        word_d     = word_q;
        k_d        = k_q;
        wid_d      = wid_q;
        tx_data_d  = '0;
        tx_k_d     = '0;
        tx_valid_d = 1'b0;
        tx_sb_d    = 1'b0;
        gen_err_d  = gen_err_q || (!gen_ok && (in_valid || pending));
        if (load) begin
            state_d    = ST_SHIFT;
            beat_d     = 2'd0;
            word_d     = src_data;
            k_d        = src_k;
            wid_d      = cur_w;
            tx_data_d  = data_slice(src_data, cur_w, 2'd0);
            tx_k_d     = k_slice(src_k, cur_w, 2'd0);
            tx_valid_d = 1'b1;
            tx_sb_d    = src_sb && (generation >= GEN3);
        end else if (state_q == ST_SHIFT && !last) begin
            beat_d     = beat_q + 2'd1;
            tx_data_d  = data_slice(word_q, wid_q, beat_q + 2'd1);
            tx_k_d     = k_slice(k_q, wid_q, beat_q + 2'd1);
            tx_valid_d = 1'b1;
        end else begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
        end
    end

    // Gearbox state and output registers.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            word_q     <= '0;
            k_q        <= '0;
            wid_q      <= '0;
            tx_data_q  <= '0;
            tx_k_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_sb_q    <= 1'b0;
            gen_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            k_q        <= k_d;
            wid_q      <= wid_d;
            tx_data_q  <= tx_data_d;
            tx_k_q     <= tx_k_d;
            tx_valid_q <= tx_valid_d;
            tx_sb_q    <= tx_sb_d;
            gen_err_q  <= gen_err_d;
        end
    end

    assign TxData       = tx_data_q;
    assign TxDataK      = tx_k_q;
    assign TxDataValid  = tx_valid_q;
    assign TxStartBlock = tx_sb_q;
    assign gen_error    = gen_err_q;

endmodule

// File: doc/pipe_tx_gearbox.md
PIPE_TX_GEARBOX -- requirements
Module: pipe_tx_gearbox

Interface
REQ-001 SHALL have parameter PIPE_WIDTH_GEN1, default 8: PIPE TxData width (bits) for Gen1.
REQ-002 SHALL have parameter PIPE_WIDTH_GEN2, default 8: PIPE width for Gen2.
REQ-003 SHALL have parameter PIPE_WIDTH_GEN3, default 16: PIPE width for Gen3.
REQ-004 SHALL have parameter PIPE_WIDTH_GEN4, default 32: PIPE width for Gen4.
REQ-005 SHALL have parameter PIPE_WIDTH_GEN5, default 32: PIPE width for Gen5.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: input FIFO entries, power of 2, ≥2; used only with PIPE_TX_FIFO_EN.
REQ-007 SHALL have ports:
  pclk  in  1  PIPE clock, all logic on rising edge
  reset_n  in  1  reset, synchronous, active-low
  generation  in  3  link generation 1..5; other values invalid
  in_data  in  32  scrambled word, byte 0 = bits 7:0, sent first
  in_k  in  4  per-byte K flag
  in_start_block  in  1  word is first word of a 128b/130b block
  in_valid  in  1  word offered
  in_ready  out  1  word accepted when in_valid && in_ready
  TxData  out  32  PIPE data, upper bits zero above width W
  TxDataK  out  4  PIPE K, upper bits zero above W/8
  TxDataValid  out  1  TxData beat valid
  TxStartBlock  out  1  first beat of a block, Gen3+ only
  gen_error  out  1  sticky: invalid generation seen while data pending

Function
REQ-008 W = PIPE_WIDTH_GENn for current generation; beats per word N = 32/W (8→4, 16→2, 32→1).
REQ-009 Generation SHALL be latched into the output stage with each word leaving the holding register; a generation change SHALL take effect only at word boundaries, never mid-word.
REQ-010 States: IDLE (no word held), SHIFT (word held, beat index 0..N-1).
REQ-011 IDLE→SHIFT on accept; SHIFT stays while beat<N-1; at beat N-1 → SHIFT(beat 0) if next word available, else IDLE.
REQ-012 Beat i SHALL drive TxData[W-1:0]=word[W*i +: W], TxDataK[W/8-1:0]=k[(W/8)*i +: W/8], TxDataValid=1; all outputs registered.
REQ-013 Latency: first beat on TxData the cycle after accept (non-FIFO) or after FIFO output (FIFO); back-to-back words SHALL produce continuous TxDataValid with no bubble.
REQ-014 TxStartBlock=1 only on beat 0 of a word accepted with in_start_block=1 and latched generation ≥3; else 0.
REQ-015 Idle (no word): TxData=0, TxDataK=0, TxDataValid=0, TxStartBlock=0.
REQ-016 Non-FIFO build: in_ready = (state==IDLE) || (beat==N-1) with generation valid.
REQ-017 Invalid generation (0,6,7): in_ready=0, no new word started, word in progress completes with its latched width; gen_error set if in_valid=1 or FIFO non-empty; cleared only by reset.
REQ-018 in_data/in_k/in_start_block SHALL be ignored when in_valid=0.

Reset
REQ-019 reset_n=0 at pclk edge: state IDLE, beat 0, FIFO empty, all outputs 0 incl. in_ready and gen_error; in-flight word discarded.
REQ-020 First accept possible the cycle after reset_n returns to 1.

Configuration
REQ-021 Macro PIPE_TX_FIFO_EN defined: FIFO_DEPTH-entry FIFO ahead of gearbox; in_ready = !full; simultaneous push at full-with-pop SHALL be accepted; pop when gearbox needs next word.
REQ-022 Macro undefined: no FIFO, single holding register, in_ready per REQ-016; FIFO_DEPTH ignored.

Structure
REQ-023 Shared package pipe_pkg SHALL hold the gearbox state enum, generation constants GEN1..GEN5, and the width→beats function.
REQ-024 FIFO SHALL be sub-module pipe_sync_fifo (parametrised width 37, depth), instantiated only under PIPE_TX_FIFO_EN.

Verification
REQ-025 Gen1, word 0x44332211 k=0b0001 → 4 beats TxData 0x11,0x22,0x33,0x44, TxDataK 1,0,0,0; in_ready low on beats 0-2.
REQ-026 Gen3, words 0xDDCCBBAA (start_block) then 0x11223344 back-to-back → beats 0xBBAA(TxStartBlock=1),0xDDCC,0x3344,0x1122, TxDataValid never drops.
REQ-027 Gen5, 8 consecutive words → one beat each, full 32 bits, in_ready constantly 1, no bubbles.
REQ-028 Generation 1→3 changed during beat 1 of a Gen1 word → beats 2,3 stay 8-bit; next word 16-bit.
REQ-029 generation=7 with in_valid=1 → in_ready=0, TxDataValid=0, gen_error=1 until reset.
REQ-030 reset_n=0 during beat 2 of Gen1 word → next cycle all outputs 0, state IDLE; with PIPE_TX_FIFO_EN, 4 words pushed while stalled → in_ready=0 at full, all words emitted in order.
